// File: rtl/k005297_dmabuscycle.sv
// K005297 bus-side DMA cycle sequencer: bus arbitration, one word per request, DMA address-counter strobes.
// Optional feature macro K005297_DMA_BURST_EN keeps the bus granted (HOLD) for back-to-back requests.
module k005297_dmabuscycle #(
  parameter logic [5:0] DTACK_TMO = 6'd63
) (
  input  logic        i_MCLK,
  input  logic        i_RST_n,
  input  logic        i_CLK4M_PCEN_n,
  input  logic [7:0]  i_ROT8,
  input  logic        i_XFER_REQ,
  input  logic        i_XFER_WR,
  input  logic        i_XFER_MSK,
  input  logic [15:0] i_DIN,
  output logic [15:0] o_DOUT,
  output logic        o_XFER_DONE,
  output logic        o_BUSERR,
  output logic        o_BR_n,
  output logic        o_BGACK_n,
  output logic        o_AS_n,
  output logic        o_UDS_n,
  output logic        o_LDS_n,
  output logic        o_R_nW,
  output logic [15:0] o_DB,
  output logic        o_DB_OE,
  input  logic        i_BG_n,
  input  logic        i_AS_n,
  input  logic        i_DTACK_n,
  input  logic [15:0] i_DB,
  output logic        o_BDRWADDR_INC,
  output logic        o_MSKADDR_INC,
  output logic        o_ADDR_RST
);

  typedef enum logic [3:0] {
    S_IDLE, S_BUSREQ, S_ACQ, S_ADDR, S_STROBE, S_WAITACK, S_TERM, S_INC, S_RELEASE
`ifdef K005297_DMA_BURST_EN
    , S_HOLD
`endif
  } state_t;

  localparam logic [5:0] TMO_LAST = DTACK_TMO - 6'd1;

  state_t     state;
  logic       wr_q;
  logic       msk_win;   // mask transfer in flight: MSKADDR_INC doubles as the A7-A1 select
  logic       msk_tail;  // hold MSKADDR_INC through one more ROT8[1] cycle after INC
  logic [5:0] tmo_cnt;
`ifdef K005297_DMA_BURST_EN
  localparam logic [2:0] HOLD_LAST = 3'd7;
  logic [2:0] hold_cnt;
`endif

  logic unused_rot;
  assign unused_rot = ^{i_ROT8[7:2], i_ROT8[0]};

  always_ff @(posedge i_MCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      state          <= S_IDLE;
      wr_q           <= 1'b0;
      msk_win        <= 1'b0;
      msk_tail       <= 1'b0;
      tmo_cnt        <= '0;
      o_DOUT         <= '0;
      o_XFER_DONE    <= 1'b0;
      o_BUSERR       <= 1'b0;
      o_BR_n         <= 1'b1;
      o_BGACK_n      <= 1'b1;
      o_AS_n         <= 1'b1;
      o_UDS_n        <= 1'b1;
      o_LDS_n        <= 1'b1;
      o_R_nW         <= 1'b1;
      o_DB           <= '0;
      o_DB_OE        <= 1'b0;
      o_BDRWADDR_INC <= 1'b0;
      o_MSKADDR_INC  <= 1'b0;
      o_ADDR_RST     <= 1'b1;
`ifdef K005297_DMA_BURST_EN
      hold_cnt       <= '0;
`endif
    end else if (!i_CLK4M_PCEN_n) begin
      o_ADDR_RST  <= 1'b0;
      o_XFER_DONE <= 1'b0;
      if (msk_tail && i_ROT8[1]) begin
        msk_tail <= 1'b0;
        if (!msk_win) o_MSKADDR_INC <= 1'b0;
      end
      case (state)
        S_IDLE: if (i_XFER_REQ) begin
          wr_q     <= i_XFER_WR;
          msk_win  <= i_XFER_MSK;
          o_DB     <= i_DIN;
          o_BUSERR <= 1'b0;
          o_BR_n   <= 1'b0;
          state    <= S_BUSREQ;
        end
        // Take the bus only once the current master has dropped AS
        S_BUSREQ: if (!i_BG_n && i_AS_n) begin
          o_BGACK_n <= 1'b0;
          o_BR_n    <= 1'b1;
          state     <= S_ACQ;
        end
        S_ACQ: begin
          o_R_nW <= ~wr_q;
          o_AS_n <= 1'b0;
          if (msk_win) o_MSKADDR_INC <= 1'b1;
          state  <= S_ADDR;
        end
        S_ADDR: begin
          o_UDS_n <= 1'b0;
          o_LDS_n <= 1'b0;
          o_DB_OE <= wr_q;
          state   <= S_STROBE;
        end
        S_STROBE: begin
          tmo_cnt <= '0;
          state   <= S_WAITACK;
        end
        S_WAITACK: if (!i_DTACK_n) begin
          if (!wr_q) o_DOUT <= i_DB;
          o_AS_n  <= 1'b1;
          o_UDS_n <= 1'b1;
          o_LDS_n <= 1'b1;
          o_DB_OE <= 1'b0;
          state   <= S_TERM;
        end else if (tmo_cnt == TMO_LAST) begin
          o_AS_n        <= 1'b1;
          o_UDS_n       <= 1'b1;
          o_LDS_n       <= 1'b1;
          o_DB_OE       <= 1'b0;
          o_BUSERR      <= 1'b1;
          msk_win       <= 1'b0;
          o_MSKADDR_INC <= 1'b0;
          o_BGACK_n     <= 1'b1;
          state         <= S_RELEASE;
        end else begin
          tmo_cnt <= tmo_cnt + 6'd1;
        end
        S_TERM: begin
          o_R_nW <= 1'b1;
          if (msk_win) o_MSKADDR_INC  <= 1'b1;
          else         o_BDRWADDR_INC <= 1'b1;
          state <= S_INC;
        end
        S_INC: if (i_ROT8[1]) begin
          o_BDRWADDR_INC <= 1'b0;
          o_XFER_DONE    <= 1'b1;
          if (msk_win) begin
            msk_win  <= 1'b0;
            msk_tail <= 1'b1;
          end
`ifdef K005297_DMA_BURST_EN
          hold_cnt <= '0;
          state    <= S_HOLD;
`else
          o_BGACK_n <= 1'b1;
          state     <= S_RELEASE;
`endif
        end
        S_RELEASE: begin
          o_R_nW <= 1'b1;
          state  <= S_IDLE;
        end
`ifdef K005297_DMA_BURST_EN
        // Bus still owned: a new request skips arbitration
        S_HOLD: if (i_XFER_REQ) begin
          wr_q     <= i_XFER_WR;
          msk_win  <= i_XFER_MSK;
          o_DB     <= i_DIN;
          o_BUSERR <= 1'b0;
          o_R_nW   <= ~i_XFER_WR;
          o_AS_n   <= 1'b0;
          if (i_XFER_MSK) o_MSKADDR_INC <= 1'b1;
          state    <= S_ADDR;
        end else if (hold_cnt == HOLD_LAST) begin
          o_BGACK_n <= 1'b1;
          state     <= S_RELEASE;
        end else begin
          hold_cnt <= hold_cnt + 3'd1;
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_k005297_dmabuscycle.sv
// Directed self-checking bench for k005297_dmabuscycle (honours K005297_DMA_BURST_EN if defined).
module tb_k005297_dmabuscycle;

  logic        i_MCLK = 1'b0;
  logic        i_RST_n = 1'b0;
  logic        pcen_n = 1'b1;
  logic [7:0]  rot8 = 8'h01;
  logic        xfer_req = 1'b0, xfer_wr = 1'b0, xfer_msk = 1'b0;
  logic [15:0] din = '0, db_in = '0;
  logic        bg_n = 1'b1, fas_n = 1'b1, dtack_n = 1'b1;

  logic [15:0] o_DOUT, o_DB;
  logic        o_XFER_DONE, o_BUSERR, o_BR_n, o_BGACK_n, o_AS_n, o_UDS_n, o_LDS_n, o_R_nW;
  logic        o_DB_OE, o_BDRWADDR_INC, o_MSKADDR_INC, o_ADDR_RST;

  int          n_assert = 0;
  int          n_fail = 0;
  logic [7:0]  last_rot;

  k005297_dmabuscycle dut (
    .i_MCLK(i_MCLK), .i_RST_n(i_RST_n), .i_CLK4M_PCEN_n(pcen_n), .i_ROT8(rot8),
    .i_XFER_REQ(xfer_req), .i_XFER_WR(xfer_wr), .i_XFER_MSK(xfer_msk), .i_DIN(din),
    .o_DOUT(o_DOUT), .o_XFER_DONE(o_XFER_DONE), .o_BUSERR(o_BUSERR),
    .o_BR_n(o_BR_n), .o_BGACK_n(o_BGACK_n), .o_AS_n(o_AS_n), .o_UDS_n(o_UDS_n),
    .o_LDS_n(o_LDS_n), .o_R_nW(o_R_nW), .o_DB(o_DB), .o_DB_OE(o_DB_OE),
    .i_BG_n(bg_n), .i_AS_n(fas_n), .i_DTACK_n(dtack_n), .i_DB(db_in),
    .o_BDRWADDR_INC(o_BDRWADDR_INC), .o_MSKADDR_INC(o_MSKADDR_INC), .o_ADDR_RST(o_ADDR_RST)
  );

  always #5 i_MCLK = ~i_MCLK;

  // 4 MHz enable on every other MCLK; rotator advances after each enabled edge
  always @(posedge i_MCLK) begin
    #1;
    if (!pcen_n) rot8 = {rot8[6:0], rot8[7]};
    pcen_n = ~pcen_n;
  end

  task automatic step();
    logic en;
    do begin
      en = !pcen_n;
      last_rot = rot8;
      @(posedge i_MCLK);
    end while (!en);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int ndone, nrise, nfall, nbdrw, nmsk, rot1cnt, ncyc;
    logic prev;

    #22;
    chk("rst_br", o_BR_n, 1);
    chk("rst_bgack", o_BGACK_n, 1);
    chk("rst_strobes", {o_AS_n, o_UDS_n, o_LDS_n, o_R_nW}, 4'hF);
    chk("rst_misc", {o_DB_OE, o_XFER_DONE, o_BUSERR, o_BDRWADDR_INC, o_MSKADDR_INC}, 5'h00);
    chk("rst_dout", o_DOUT, 16'h0000);
    chk("rst_addr_rst", o_ADDR_RST, 1);
    i_RST_n = 1'b1;
    step();
    chk("addr_rst_clear", o_ADDR_RST, 0);

    // Data write, grant after 2 cycles, DTACK on 3rd WAITACK cycle
    xfer_req = 1'b1; xfer_wr = 1'b1; xfer_msk = 1'b0; din = 16'hA55A;
    step();
    chk("a_br_low", o_BR_n, 0);
    xfer_req = 1'b0;
    step(); step();
    chk("a_wait_grant", {o_BR_n, o_BGACK_n}, 2'b01);
    bg_n = 1'b0;
    step();
    chk("a_acq", {o_BR_n, o_BGACK_n}, 2'b10);
    bg_n = 1'b1;
    step();
    chk("a_addr", {o_AS_n, o_UDS_n, o_R_nW}, 3'b010);
    step();
    chk("a_strobe", {o_UDS_n, o_LDS_n, o_DB_OE, o_R_nW}, 4'b0010);
    chk("a_db", o_DB, 16'hA55A);
    step(); step(); step();
    chk("a_waiting", {o_AS_n, o_UDS_n}, 2'b00);
    dtack_n = 1'b0;
    step();
    dtack_n = 1'b1;
    chk("a_term", {o_AS_n, o_UDS_n, o_LDS_n, o_DB_OE}, 4'b1110);
    ndone = 0; nrise = 0; nfall = 0; nmsk = 0;
    for (int i = 0; i < 20; i++) begin
      prev = o_BDRWADDR_INC;
      step();
      if (o_XFER_DONE) ndone++;
      if (o_MSKADDR_INC) nmsk++;
      if (!prev && o_BDRWADDR_INC) nrise++;
      if (prev && !o_BDRWADDR_INC) begin
        nfall++;
        chk("a_inc_end_rot1", last_rot[1], 1);
        chk("a_done_with_inc_end", o_XFER_DONE, 1);
      end
    end
    chk("a_inc_windows", {nrise[3:0], nfall[3:0]}, 8'h11);
    chk("a_done_count", ndone, 1);
    chk("a_no_msk_inc", nmsk, 0);
    chk("a_released", {o_BR_n, o_BGACK_n}, 2'b11);

    // Mask read with grant already present, immediate DTACK
    bg_n = 1'b0; dtack_n = 1'b0; db_in = 16'h1234;
    xfer_req = 1'b1; xfer_wr = 1'b0; xfer_msk = 1'b1;
    step();
    xfer_req = 1'b0;
    step(); step();
    chk("b_addr", {o_AS_n, o_R_nW, o_MSKADDR_INC}, 3'b011);
    step(); step(); step();
    chk("b_dout", o_DOUT, 16'h1234);
    dtack_n = 1'b1;
    step();
    chk("b_inc_entry", {o_MSKADDR_INC, o_BDRWADDR_INC}, 2'b10);
    ndone = 0; nbdrw = 0; rot1cnt = 0; nfall = 0;
    for (int i = 0; i < 30; i++) begin
      prev = o_MSKADDR_INC;
      step();
      if (prev && last_rot[1]) rot1cnt++;
      if (o_XFER_DONE) ndone++;
      if (o_BDRWADDR_INC) nbdrw++;
      if (prev && !o_MSKADDR_INC) begin
        nfall++;
        chk("b_msk_rot1_edges", rot1cnt, 2);
      end
    end
    chk("b_msk_fell_once", nfall, 1);
    chk("b_done_count", ndone, 1);
    chk("b_no_bdrw_inc", nbdrw, 0);

    // No DTACK: timeout after 63 WAITACK cycles
    xfer_req = 1'b1; xfer_wr = 1'b0; xfer_msk = 1'b0;
    step();
    xfer_req = 1'b0;
    step(); step(); step(); step();
    ncyc = 0;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (o_BUSERR) begin ncyc = i; break; end
    end
    chk("c_tmo_cycles", ncyc, 63);
    chk("c_tmo_bus", {o_AS_n, o_UDS_n, o_LDS_n, o_BGACK_n}, 4'hF);
    chk("c_tmo_no_inc", {o_BDRWADDR_INC, o_MSKADDR_INC, o_XFER_DONE}, 3'b000);
    step();
    chk("c_buserr_sticky", o_BUSERR, 1);

    // Foreign AS held low while grant arrives
    fas_n = 1'b0;
    xfer_req = 1'b1; xfer_wr = 1'b1; xfer_msk = 1'b0; din = 16'h5AA5;
    step();
    chk("d_buserr_cleared", o_BUSERR, 0);
    xfer_req = 1'b0;
    step(); step();
    chk("d_blocked", {o_BR_n, o_BGACK_n}, 2'b01);
    fas_n = 1'b1;
    step();
    chk("d_acq", o_BGACK_n, 0);
    dtack_n = 1'b0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (o_XFER_DONE) begin ndone = 1; break; end
    end
    chk("d_done", ndone, 1);
    dtack_n = 1'b1;

    // Second request 3 cycles after INC
    step(); step();
    xfer_req = 1'b1; xfer_wr = 1'b0;
    step();
    xfer_req = 1'b0;
`ifdef K005297_DMA_BURST_EN
    chk("e_burst_hold", {o_BR_n, o_BGACK_n, o_AS_n}, 3'b100);
    step(); step();
`else
    chk("e_rearbitrate", {o_BR_n, o_BGACK_n}, 2'b01);
    step(); step(); step(); step();
`endif
    chk("e_in_waitack", {o_AS_n, o_UDS_n, o_BGACK_n}, 3'b000);

    // Asynchronous reset mid-WAITACK
    #2;
    i_RST_n = 1'b0;
    #1;
    chk("f_rst_strobes", {o_AS_n, o_UDS_n, o_LDS_n, o_BR_n, o_BGACK_n}, 5'h1F);
    chk("f_rst_addr_rst", {o_ADDR_RST, o_DB_OE}, 2'b10);
    repeat (3) @(posedge i_MCLK);
    #2;
    i_RST_n = 1'b1;
    step();
    chk("f_idle_after_rst", {o_ADDR_RST, o_BR_n, o_BGACK_n, o_AS_n}, 4'b0111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/k005297_dmabuscycle.md
# k005297_dmabuscycle

Bus-side DMA cycle sequencer for the K005297 bubble memory controller. It arbitrates for the 68000-style host bus, runs one word transfer per request (bubble data to/from RAM, or an error-map word), and drives the increment and select strobes of the DMA address counter so the address presented on A7-A1 tracks completed transfers. It sits between the bubble data path and the host bus interface.

## Interface
Parameters:
- DTACK_TMO, 6'd63, 4 MHz enable cycles to wait for DTACK before aborting.

Ports:
- i_MCLK  in  1  master clock
- i_RST_n  in  1  asynchronous, active-low reset
- i_CLK4M_PCEN_n  in  1  4 MHz clock enable, active low; all state advances only on enabled cycles
- i_ROT8  in  8  one-hot timing rotator
- i_XFER_REQ  in  1  request one word transfer; sampled in IDLE or HOLD only
- i_XFER_WR  in  1  1 = write to RAM, 0 = read from RAM; captured with request
- i_XFER_MSK  in  1  1 = error-map transfer, 0 = bubble-data transfer; captured with request
- i_DIN  in  16  write data; captured with request
- o_DOUT  out  16  read data, latched at DTACK
- o_XFER_DONE  out  1  one-enable-cycle pulse on successful completion
- o_BUSERR  out  1  sticky timeout flag; cleared by next accepted request
- o_BR_n, o_BGACK_n, o_AS_n, o_UDS_n, o_LDS_n  out  1 each  bus control, active low
- o_R_nW  out  1  read/write
- o_DB  out  16  data bus; o_DB_OE  out  1  data drive enable
- i_BG_n, i_AS_n, i_DTACK_n  in  1 each  bus grant, foreign AS, acknowledge
- i_DB  in  16  data bus input
- o_BDRWADDR_INC, o_MSKADDR_INC  out  1 each  address counter controls
- o_ADDR_RST  out  1  mirrors i_XFER_REQ & ~busy is NOT used; driven only by reset (high while i_RST_n low, one enable cycle after release)

## Operation
- Reset values: BR_n, BGACK_n, AS_n, UDS_n, LDS_n, R_nW = 1; DB_OE, XFER_DONE, BUSERR, both INC = 0; DOUT = 0; ADDR_RST = 1; state IDLE.
- States: IDLE -> BUSREQ (request accepted; BR_n=0) -> ACQ when i_BG_n=0 and i_AS_n=1 (BGACK_n=0, BR_n=1) -> ADDR (R_nW set, AS_n=0) -> STROBE (UDS_n=LDS_n=0; DB_OE=1 if write) -> WAITACK -> TERM on i_DTACK_n=0 (latch i_DB into DOUT if read; negate AS/UDS/LDS, DB_OE=0) -> INC -> RELEASE (BGACK_n=1) -> IDLE.
- WAITACK timeout: counter reaches DTACK_TMO -> negate strobes, BUSERR=1, skip INC, go RELEASE; no XFER_DONE.
- INC: o_BDRWADDR_INC (data) or o_MSKADDR_INC (mask) held high until an enabled cycle with i_ROT8[1]=1, inclusive; XFER_DONE pulses on that cycle.
- o_MSKADDR_INC additionally held high from ADDR through INC for mask transfers (counter uses it as A7-A1 select), and for one further i_ROT8[1] enabled cycle after INC (counter latches then counts).
- i_XFER_REQ outside IDLE/HOLD is ignored (no queueing).
- i_RST_n low mid-cycle: all bus outputs negate immediately (asynchronous), state IDLE.

## Timing
- Accepted request to AS_n low: 3 enabled cycles minimum (BUSREQ, ACQ, ADDR) plus grant wait.
- AS_n low to UDS/LDS low: 1 enabled cycle; DTACK sampled every enabled cycle from WAITACK.
- DTACK sample to strobes negated: 1 enabled cycle; DOUT valid same edge.
- Bus control outputs are registered; no combinational paths from bus inputs.

## Configuration
- K005297_DMA_BURST_EN defined: after INC, enter HOLD keeping BGACK_n=0 for up to 8 enabled cycles; a request in HOLD goes directly to ADDR; expiry -> RELEASE. Undefined: INC always -> RELEASE; HOLD state absent.

## Test plan
- Reset: hold i_RST_n low mid-WAITACK -> all strobes 1, ADDR_RST=1, state IDLE.
- Data write, DIN=16'hA55A, BG after 2 cycles, DTACK after 3 -> o_DB=16'hA55A with DB_OE=1, R_nW=0, one BDRWADDR_INC window ending on ROT8[1], one XFER_DONE.
- Mask read, i_DB=16'h1234 -> DOUT=16'h1234, MSKADDR_INC high ADDR through second ROT8[1] after INC, BDRWADDR_INC never high.
- No DTACK -> BUSERR=1 after 63 WAITACK cycles, no INC, BGACK_n=1; next request clears BUSERR.
- Foreign AS_n low when BG_n falls -> stay BUSREQ until i_AS_n=1.
- With K005297_DMA_BURST_EN, second request 3 cycles after INC -> BGACK_n stays 0, BR_n not reasserted; without it BR_n reasserts.
